square_animator: RTL and testbench
==================================

// Module: square_animator
// PURPOSE
//   Parametrised renderer for N coloured squares that bounce around the visible area.
//   Sits between the 640x480 VGA timing generator and the board RGB pins:
//   - takes the current pixel x/y, active-video flag and an end-of-frame strobe;
//   - each frame, moves every square by its velocity and reflects it off the screen edges;
//   - outputs registered 4-bit-per-channel colour.
// PARAMETERS
//   N_SQ      4                         number of squares (1..8)
//   SIZE      160                       square edge length in pixels (<= V_RES)
//   SPEED     1                         pixels moved per axis per animate strobe (1..SIZE)
//   H_RES     640                       visible width in pixels
//   V_RES     480                       visible height in pixels
//   CW        4                         colour bits per channel
//   INIT_X    {10'd360,10'd280,10'd200,10'd120}  packed N_SQ*10; square i start x in bits [10i+:10]
//   INIT_Y    {9'd280,9'd200,9'd120,9'd40}       packed N_SQ*9; start y
//   INIT_DIR  8'b00_11_10_01            packed N_SQ*2; bit 2i = x dir (1 = +), bit 2i+1 = y dir (1 = +)
//   COLOUR    {12'h0F0,12'h00F,12'hF00,12'h0F0}  packed N_SQ*3*CW; {R,G,B} of square i
//   MIX       0                         0 = priority (lowest index on top), 1 = bitwise OR of overlaps
// PORTS
//   i_clk       in   1          system clock (100 MHz)
//   i_rst       in   1          synchronous, active-high reset
//   i_pix_stb   in   1          pixel strobe; 1 cycle in 4
//   i_x         in   10         current pixel x
//   i_y         in   9          current pixel y
//   i_active    in   1          high while (i_x, i_y) is in visible area
//   i_animate   in   1          one-cycle pulse, once per frame, during blanking
//   i_pause     in   1          high: squares hold position
//   o_r         out  CW         red
//   o_g         out  CW         green
//   o_b         out  CW         blue
// BEHAVIOUR
// - Reset (i_rst high at a rising edge):
//   - every square loads INIT_X/INIT_Y/INIT_DIR;
//   - o_r/o_g/o_b go to 0 on that edge;
//   - reset wins over i_animate in the same cycle.
// - Hit test (combinational per square):
//   - hit_i = (i_x >= x_i) & (i_x < x_i+SIZE) & (i_y >= y_i) & (i_y < y_i+SIZE);
//   - sums are compared in 11 bits (x) and 10 bits (y), so no wrap.
// - Colour:
//   - MIX=0: colour of the lowest-index square with hit_i set;
//   - MIX=1: OR of COLOUR over all squares with hit_i set;
//   - no hit, or i_active low: 0.
// - Output register:
//   - updates only on cycles where i_pix_stb=1; holds otherwise;
//   - latency: exactly one pixel strobe after i_x/i_y are presented.
// - Motion: on i_animate=1 with i_pause=0, each square updates both axes in the same cycle.
//   - x, dir +: if x+SPEED+SIZE > H_RES then x <= H_RES-SIZE and dir <= -, else x <= x+SPEED.
//   - x, dir -: if x < SPEED then x <= 0 and dir <= +, else x <= x-SPEED.
//   - y: same rule with V_RES.
//   - Corner hit: both axes flip in the same update.
// - Strobe handling:
//   - i_animate is level-sampled; a pulse longer than one cycle moves the square once per cycle
//     (caller must pulse);
//   - i_pause=1 with i_animate: no movement and no direction change.
// - Invariant: 0 <= x_i <= H_RES-SIZE and 0 <= y_i <= V_RES-SIZE at all times after reset.
// STRUCTURE
// - Shared include vga_params.vh: H_RES, V_RES, X_W=10, Y_W=9, default CW.
// - Sub-module square_sprite, one instance per square (generate loop).
//   - Holds the x/y/dir registers, the bounce logic and the hit comparator.
//   - Ports: i_clk, i_rst, i_animate, i_pause, i_x, i_y, o_hit.
// - Top level: priority/OR mixer plus the output register.
// TESTING
// - Reset, default params: x=121,y=41 (i_active=1) -> one strobe later o_g=4'hF, o_r=o_b=0;
//   x=120,y=41 -> sq0 (x=120) hit (inclusive lower).
// - Overlap MIX=0: x=210,y=130 -> green (sq0 over sq1); MIX=1 -> o_r=o_g=4'hF.
// - Right bounce: SIZE=160, SPEED=3, sq x=478 dir + -> after animate x=480, dir -;
//   next animate x=477.
// - Left/top corner: x=1,y=2, SPEED=3, both dir - -> x=0,y=0, both dirs +.
// - i_pause=1 with 10 animate pulses -> positions and dirs unchanged;
//   i_active=0 -> o_r=o_g=o_b=0.
// - i_rst asserted mid-run on the same cycle as i_animate -> INIT positions, outputs 0;
//   no move applied.

Source files
------------

// File: rtl/square_animator_pkg.sv
// square_animator_pkg: shared VGA geometry constants and the per-axis bounce step
package square_animator_pkg;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_CW = 4;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int P_W = 12;
  typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;
  // returns {new_dir, new_pos}; lim is the largest legal position on this axis
  function automatic logic [P_W:0] bounce(input logic [P_W-1:0] p, input logic d,
                                          input logic [P_W-1:0] s, input logic [P_W-1:0] lim);
    if (d) return (p + s > lim) ? {DIR_NEG, lim} : {DIR_POS, p + s};
    return (p < s) ? {DIR_POS, {P_W{1'b0}}} : {DIR_NEG, p - s};
  endfunction
endpackage

// File: rtl/square_sprite.sv
// square_sprite: one bouncing square's position/direction state and pixel hit test
module square_sprite
  import square_animator_pkg::*;
#(
  parameter int SIZE = 160,
  parameter int SPEED = 1,
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter logic [X_W-1:0] IX = '0,
  parameter logic [Y_W-1:0] IY = '0,
  parameter logic [1:0] IDIR = 2'b11
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_animate,
  input  logic           i_pause,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  output logic           o_hit
);
  localparam logic [P_W-1:0] SPD = P_W'(SPEED);
  localparam logic [P_W-1:0] SZ = P_W'(SIZE);
  localparam logic [P_W-1:0] XL = P_W'(H_RES - SIZE);
  localparam logic [P_W-1:0] YL = P_W'(V_RES - SIZE);
  logic [P_W-1:0] r_x, r_y, w_px, w_py;
  dir_t r_dx, r_dy;
  logic [P_W:0] w_nx, w_ny;
  // positions kept wide so edge sums never wrap
  assign w_px = {{(P_W-X_W){1'b0}}, i_x};
  assign w_py = {{(P_W-Y_W){1'b0}}, i_y};
  assign w_nx = bounce(r_x, r_dx, SPD, XL);
  assign w_ny = bounce(r_y, r_dy, SPD, YL);
  assign o_hit = (w_px >= r_x) && (w_px < r_x + SZ) && (w_py >= r_y) && (w_py < r_y + SZ);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x  <= P_W'(IX);
      r_y  <= P_W'(IY);
      r_dx <= dir_t'(IDIR[0]);
      r_dy <= dir_t'(IDIR[1]);
    end else if (i_animate && !i_pause) begin
      r_x  <= w_nx[P_W-1:0];
      r_y  <= w_ny[P_W-1:0];
      r_dx <= dir_t'(w_nx[P_W]);
      r_dy <= dir_t'(w_ny[P_W]);
    end
  end
endmodule

// File: rtl/square_animator.sv
// square_animator: N bouncing squares mixed by priority or OR into registered VGA colour
module square_animator
  import square_animator_pkg::*;
#(
  parameter int N_SQ = 4,
  parameter int SIZE = 160,
  parameter int SPEED = 1,
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int CW = DEF_CW,
  parameter logic [N_SQ*X_W-1:0] INIT_X = {10'd360, 10'd280, 10'd200, 10'd120},
  parameter logic [N_SQ*Y_W-1:0] INIT_Y = {9'd280, 9'd200, 9'd120, 9'd40},
  parameter logic [N_SQ*2-1:0] INIT_DIR = 8'b00_11_10_01,
  parameter logic [N_SQ*3*CW-1:0] COLOUR = {12'h0F0, 12'h00F, 12'hF00, 12'h0F0},
  parameter int MIX = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_pix_stb,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  input  logic           i_active,
  input  logic           i_animate,
  input  logic           i_pause,
  output logic [CW-1:0]  o_r,
  output logic [CW-1:0]  o_g,
  output logic [CW-1:0]  o_b
);
  logic [N_SQ-1:0] w_hit;
  logic [3*CW-1:0] w_pri, w_or, w_col, r_rgb;
  for (genvar g = 0; g < N_SQ; g++) begin : g_sq
    square_sprite #(
      .SIZE(SIZE), .SPEED(SPEED), .H_RES(H_RES), .V_RES(V_RES),
      .IX(INIT_X[X_W*g +: X_W]), .IY(INIT_Y[Y_W*g +: Y_W]), .IDIR(INIT_DIR[2*g +: 2])
    ) u_sq (
      .i_clk(i_clk), .i_rst(i_rst), .i_animate(i_animate), .i_pause(i_pause),
      .i_x(i_x), .i_y(i_y), .o_hit(w_hit[g])
    );
  end
  // walking from the top index down leaves the lowest-index hit in w_pri
  always_comb begin
    w_pri = '0;
    w_or = '0;
    for (int i = N_SQ - 1; i >= 0; i--) begin
      w_pri = w_hit[i] ? COLOUR[3*CW*i +: 3*CW] : w_pri;
      w_or = w_or | (w_hit[i] ? COLOUR[3*CW*i +: 3*CW] : '0);
    end
    w_col = (MIX != 0) ? w_or : w_pri;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rgb <= '0;
    else if (i_pix_stb) r_rgb <= i_active ? w_col : '0;
  end
  assign {o_r, o_g, o_b} = r_rgb;
endmodule

// File: tb/tb_square_animator.sv
// tb_square_animator: random pixel probes on two configurations against a geometric model
module tb_square_animator;
  logic clk = 0, rst = 1, stb = 0, act = 0, anim = 0, pause = 0;
  logic [9:0] px = 0;
  logic [8:0] py = 0;
  logic [3:0] ar, ag, ab, br, bg, bb;
  int n_chk = 0, n_pass = 0;
  logic [11:0] col [4] = '{12'h0F0, 12'hF00, 12'h00F, 12'h0F0};
  int mx [2][4], my [2][4];
  bit mdx [2][4], mdy [2][4];
  int spd [2] = '{1, 3};
  bit mix [2] = '{0, 1};

  always #5 clk = ~clk;

  square_animator u_a (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_x(px), .i_y(py), .i_active(act),
    .i_animate(anim), .i_pause(pause), .o_r(ar), .o_g(ag), .o_b(ab)
  );
  square_animator #(
    .SPEED(3), .MIX(1),
    .INIT_X({10'd1, 10'd478, 10'd200, 10'd120}),
    .INIT_Y({9'd2, 9'd300, 9'd120, 9'd40})
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_x(px), .i_y(py), .i_active(act),
    .i_animate(anim), .i_pause(pause), .o_r(br), .o_g(bg), .o_b(bb)
  );

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic m_reset();
    mx[0] = '{120, 200, 280, 360};
    my[0] = '{40, 120, 200, 280};
    mx[1] = '{120, 200, 478, 1};
    my[1] = '{40, 120, 300, 2};
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++) begin
        mdx[n][k] = (k == 0 || k == 2);
        mdy[n][k] = (k == 1 || k == 2);
      end
  endtask

  task automatic m_move();
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++) begin
        if (mdx[n][k]) begin
          if (mx[n][k] + spd[n] + 160 > 640) begin mx[n][k] = 480; mdx[n][k] = 0; end
          else mx[n][k] += spd[n];
        end else begin
          if (mx[n][k] < spd[n]) begin mx[n][k] = 0; mdx[n][k] = 1; end
          else mx[n][k] -= spd[n];
        end
        if (mdy[n][k]) begin
          if (my[n][k] + spd[n] + 160 > 480) begin my[n][k] = 320; mdy[n][k] = 0; end
          else my[n][k] += spd[n];
        end else begin
          if (my[n][k] < spd[n]) begin my[n][k] = 0; mdy[n][k] = 1; end
          else my[n][k] -= spd[n];
        end
      end
  endtask

  function automatic logic [11:0] m_col(input int n, input int x, input int y, input bit a);
    logic [11:0] c = '0;
    if (!a) return '0;
    for (int k = 3; k >= 0; k--)
      if (x >= mx[n][k] && x < mx[n][k] + 160 && y >= my[n][k] && y < my[n][k] + 160)
        c = mix[n] ? (c | col[k]) : col[k];
    return c;
  endfunction

  task automatic animate();
    @(negedge clk);
    anim = 1;
    @(negedge clk);
    anim = 0;
    if (!pause) m_move();
  endtask

  task automatic probe(input int x, input int y, input bit a);
    logic [11:0] ea, eb;
    ea = m_col(0, x, y, a);
    eb = m_col(1, x, y, a);
    @(negedge clk);
    px = 10'(x); py = 9'(y); act = a; stb = 1;
    @(negedge clk);
    stb = 0;
    check("A colour", {ar, ag, ab}, ea);
    check("B colour", {br, bg, bb}, eb);
    px = 10'($urandom); py = 9'($urandom); act = 1;
    @(negedge clk);
    check("A hold", {ar, ag, ab}, ea);
    check("B hold", {br, bg, bb}, eb);
  endtask

  task automatic edge_probe();
    int n, k, x, y;
    n = $urandom_range(0, 1);
    k = $urandom_range(0, 3);
    x = mx[n][k] + int'($urandom_range(0, 163)) - 2;
    y = my[n][k] + int'($urandom_range(0, 163)) - 2;
    x = (x < 0) ? 0 : (x > 639) ? 639 : x;
    y = (y < 0) ? 0 : (y > 479) ? 479 : y;
    probe(x, y, $urandom_range(0, 9) != 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    m_reset();
    check("A reset out", {ar, ag, ab}, 12'h000);
    check("B reset out", {br, bg, bb}, 12'h000);
    probe(121, 41, 1);
    check("A 121,41", {ar, ag, ab}, 12'h0F0);
    probe(120, 41, 1);
    check("A 120,41 incl", {ar, ag, ab}, 12'h0F0);
    probe(210, 130, 1);
    check("A overlap pri", {ar, ag, ab}, 12'h0F0);
    check("B overlap or", {br, bg, bb}, 12'hFF0);
    probe(479, 400, 1);
    check("B sq2 pre", {br, bg, bb}, 12'h00F);
    probe(0, 0, 1);
    check("B corner pre", {br, bg, bb}, 12'h000);
    animate();
    probe(479, 400, 1);
    check("B right clamp", {br, bg, bb}, 12'h000);
    probe(480, 400, 1);
    check("B at 480", {br, bg, bb}, 12'h00F);
    probe(0, 0, 1);
    check("B corner 0,0", {br, bg, bb}, 12'h0F0);
    animate();
    probe(477, 400, 1);
    check("B back 477", {br, bg, bb}, 12'h00F);
    probe(2, 2, 1);
    check("B corner flip", {br, bg, bb}, 12'h000);
    pause = 1;
    repeat (10) animate();
    pause = 0;
    repeat (20) edge_probe();
    probe(125, 45, 0);
    check("A inactive", {ar, ag, ab}, 12'h000);
    check("B inactive", {br, bg, bb}, 12'h000);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pause = ($urandom_range(0, 3) == 0);
        animate();
        pause = 0;
      end else edge_probe();
    end
    probe(mx[0][0], my[0][0], 1);
    @(negedge clk);
    rst = 1; anim = 1;
    @(negedge clk);
    rst = 0; anim = 0;
    m_reset();
    check("A rst+anim out", {ar, ag, ab}, 12'h000);
    check("B rst+anim out", {br, bg, bb}, 12'h000);
    probe(120, 40, 1);
    check("A init pos", {ar, ag, ab}, 12'h0F0);
    check("B init pos", {br, bg, bb}, 12'h0F0);
    probe(119, 40, 1);
    check("A init left", {ar, ag, ab}, 12'h000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
